// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder with valid/ready handshake
// Full adder built from two half_adder cells plus an OR; carry is registered between bits.

module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s1, c1, bit_sum, c2, fa_carry;
  logic             last_bit;

  half_adder u_ha0 (.x(a_sr[0]), .y(b_sr[0]), .s(s1),      .c(c1));
  half_adder u_ha1 (.x(s1),      .y(carry),   .s(bit_sum), .c(c2));

  assign fa_carry = c1 | c2;
  assign last_bit = (cnt == LAST);
  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last_bit)  state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Counter holds at LAST on the final bit so it never wraps for power-of-two widths.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr      <= '0;
      b_sr      <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr      <= a;
            b_sr      <= b;
            carry     <= cin;
            cnt       <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
          end
        end
        RUN: begin
          a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
          sum   <= {bit_sum, sum[WIDTH-1:1]};
          carry <= fa_carry;
          if (last_bit) begin
            out_valid <= 1'b1;
            carry_out <= fa_carry;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder (WIDTH=8 and WIDTH=4)

module tb_serial_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid8, in_ready8, cin8, out_valid8, out_ready8, carry_out8, busy8;
  logic [7:0] a8, b8, sum8;
  logic       in_valid4, in_ready4, cin4, out_valid4, out_ready4, carry_out4, busy4;
  logic [3:0] a4, b4, sum4;

  int errors = 0;
  int checks = 0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .carry_out(carry_out8), .busy(busy8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .carry_out(carry_out4), .busy(busy4)
  );

  // Issue one op on dut8 from IDLE; returns posedges from accept to out_valid and the result.
  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        output int lat, output logic [8:0] res);
    int n;
    n = 0;
    while (!in_ready8 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (!in_ready8) begin
      errors++;
      $display("FAIL op8_in_ready_timeout got=%0b want=1", in_ready8);
    end
    a8 = a; b8 = b; cin8 = c; in_valid8 = 1'b1; out_ready8 = 1'b0;
    @(negedge clk);
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 50) begin @(negedge clk); lat++; end
    res = {carry_out8, sum8};
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b1; out_ready8 = 1'b0;
    in_valid4 = 1'b1; a4 = 4'hF; b4 = 4'h1; cin4 = 1'b1; out_ready4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (in_ready8 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready8); end
    checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid8); end
    checks++; if (sum8 !== 8'h00) begin errors++; $display("FAIL reset_sum got=%h want=00", sum8); end
    checks++; if (carry_out8 !== 1'b0) begin errors++; $display("FAIL reset_carry_out got=%b want=0", carry_out8); end
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy8); end
    checks++; if ({busy4, out_valid4, in_ready4} !== 3'b001) begin errors++; $display("FAIL reset_dut4 got=%b want=001", {busy4, out_valid4, in_ready4}); end
    rst = 1'b0; in_valid8 = 1'b0; in_valid4 = 1'b0;
    @(negedge clk);
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_no_accept got=%b want=0", busy8); end
  endtask

  task automatic test_basic;
    logic [7:0] va[6];
    logic [7:0] vb[6];
    logic       vc[6];
    logic [8:0] res, exp;
    int lat;
    va[0] = 8'hFF; vb[0] = 8'h01; vc[0] = 1'b0;
    va[1] = 8'hA5; vb[1] = 8'h5A; vc[1] = 1'b1;
    va[2] = 8'h3C; vb[2] = 8'h0F; vc[2] = 1'b0;
    for (int i = 3; i < 6; i++) begin
      va[i] = 8'($urandom); vb[i] = 8'($urandom); vc[i] = 1'($urandom);
    end
    for (int i = 0; i < 6; i++) begin
      exp = 9'(va[i]) + 9'(vb[i]) + 9'(vc[i]);
      do_op8(va[i], vb[i], vc[i], lat, res);
      checks++; if (lat != 8) begin errors++; $display("FAIL basic_latency[%0d] got=%0d want=8", i, lat); end
      checks++; if (res !== exp) begin errors++; $display("FAIL basic_result[%0d] got=%h want=%h", i, res, exp); end
    end
  endtask

  task automatic test_backpressure;
    logic [8:0] exp1, exp2;
    logic [7:0] a2, b2;
    int n;
    a8 = 8'hC3; b8 = 8'h7E; cin8 = 1'b1; in_valid8 = 1'b1; out_ready8 = 1'b0;
    exp1 = 9'(8'hC3) + 9'(8'h7E) + 9'd1;
    n = 0;
    while (!out_valid8 && n < 50) begin
      @(negedge clk); n++;
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom);
      checks++;
      if ({out_valid8, in_ready8, carry_out8, sum8} !== {1'b1, 1'b0, exp1}) begin
        errors++;
        $display("FAIL bp_hold[%0d] got=v%b r%b %h want=v1 r0 %h", i, out_valid8, in_ready8, {carry_out8, sum8}, exp1);
      end
    end
    a2 = 8'h12; b2 = 8'h34;
    a8 = a2; b8 = b2; cin8 = 1'b0; in_valid8 = 1'b1; out_ready8 = 1'b1;
    exp2 = 9'(a2) + 9'(b2);
    @(negedge clk);
    out_ready8 = 1'b0;
    checks++; if ({out_valid8, in_ready8, busy8} !== 3'b010) begin errors++; $display("FAIL bp_release got=%b want=010", {out_valid8, in_ready8, busy8}); end
    @(negedge clk);
    in_valid8 = 1'b0;
    checks++; if ({in_ready8, busy8} !== 2'b01) begin errors++; $display("FAIL bp_next_accept got=%b want=01", {in_ready8, busy8}); end
    n = 0;
    while (!out_valid8 && n < 50) begin @(negedge clk); n++; end
    checks++; if ({carry_out8, sum8} !== exp2) begin errors++; $display("FAIL bp_second_result got=%h want=%h", {carry_out8, sum8}, exp2); end
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [8:0] res;
    int lat;
    logic seen;
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; in_valid8 = 1'b1; out_ready8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({in_ready8, out_valid8, busy8, carry_out8, sum8} !== {4'b1000, 8'h00}) begin
      errors++;
      $display("FAIL midrst_state got=r%b v%b b%b %h want=r1 v0 b0 000", in_ready8, out_valid8, busy8, {carry_out8, sum8});
    end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid8) seen = 1'b1;
    end
    out_ready8 = 1'b0;
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_output got=%b want=0", seen); end
    do_op8(8'h01, 8'h01, 1'b0, lat, res);
    checks++; if (res !== 9'h002) begin errors++; $display("FAIL midrst_next_op got=%h want=002", res); end
  endtask

  task automatic test_back_to_back;
    logic [8:0] q[$];
    int acc[$];
    logic [8:0] exp;
    logic [7:0] ra, rb;
    logic rc;
    int nres;
    nres = 0;
    out_ready8 = 1'b1; in_valid8 = 1'b1;
    for (int cyc = 0; cyc < 64; cyc++) begin
      if (out_valid8) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL b2b_unexpected_result got=%h want=none", {carry_out8, sum8});
        end else begin
          exp = q.pop_front();
          nres++;
          if ({carry_out8, sum8} !== exp) begin errors++; $display("FAIL b2b_result got=%h want=%h", {carry_out8, sum8}, exp); end
        end
      end
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      a8 = ra; b8 = rb; cin8 = rc;
      if (in_ready8) begin
        q.push_back(9'(ra) + 9'(rb) + 9'(rc));
        acc.push_back(cyc);
      end
      @(negedge clk);
    end
    in_valid8 = 1'b0;
    for (int k = 0; k < 20 && q.size() > 0; k++) begin
      if (out_valid8) begin
        checks++;
        exp = q.pop_front();
        nres++;
        if ({carry_out8, sum8} !== exp) begin errors++; $display("FAIL b2b_drain_result got=%h want=%h", {carry_out8, sum8}, exp); end
      end
      @(negedge clk);
    end
    out_ready8 = 1'b0;
    checks++; if (q.size() != 0) begin errors++; $display("FAIL b2b_drain_timeout got=%0d pending want=0", q.size()); end
    checks++; if (acc.size() < 5) begin errors++; $display("FAIL b2b_accept_count got=%0d want>=5", acc.size()); end
    for (int i = 1; i < acc.size(); i++) begin
      checks++;
      if (acc[i] - acc[i-1] != 10) begin errors++; $display("FAIL b2b_spacing[%0d] got=%0d want=10", i, acc[i] - acc[i-1]); end
    end
  endtask

  task automatic test_exhaustive4;
    logic [4:0] q[$];
    logic [4:0] exp;
    logic [8:0] v;
    int idx, done, cyc;
    idx = 0; done = 0; cyc = 0;
    while (done < 512 && cyc < 20000) begin
      out_ready4 = ($urandom_range(0, 3) != 0);
      if (out_valid4 && out_ready4) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL exh_unexpected_result got=%h want=none", {carry_out4, sum4});
        end else begin
          exp = q.pop_front();
          if ({carry_out4, sum4} !== exp) begin errors++; $display("FAIL exh_result[%0d] got=%h want=%h", done, {carry_out4, sum4}, exp); end
        end
        done++;
      end
      in_valid4 = (idx < 512);
      v = 9'(idx);
      a4 = v[8:5]; b4 = v[4:1]; cin4 = v[0];
      if (in_valid4 && in_ready4) begin
        q.push_back(5'(a4) + 5'(b4) + 5'(cin4));
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid4 = 1'b0; out_ready4 = 1'b0;
    checks++; if (done != 512) begin errors++; $display("FAIL exh_count got=%0d want=512", done); end
  endtask

  initial begin
    rst = 1'b1;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_exhaustive4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
